// File: rtl/sga_pkg.sv
// Shared constants and state encoding for the SGA LED matrix scanner.
package sga_pkg;

  localparam int DEF_ROWS = 6;
  localparam int DEF_COLS = 6;
  localparam int FRAME_W  = DEF_ROWS * DEF_COLS;
  localparam int ROW_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_timer.sv
// Terminal-count counter: counts 0..LIMIT-1 while en is high, wraps on tc.
module scan_timer #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] count_q;

  assign tc = (count_q == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= tc ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered row-multiplexed LED matrix driver; frames swap only at frame boundaries.
// Optional anti-ghosting blank between rows: define SCAN_BLANK_EN.
module led_matrix_scanner
  import sga_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int COLS         = DEF_COLS,
  parameter int DWELL        = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [ROWS*COLS-1:0]   frame,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  output logic [ROWS-1:0]        row_sel,
  output logic [COLS-1:0]        col_data,
  output logic [ROW_W-1:0]       row_idx,
  output logic                   frame_done
);

  localparam int FW = ROWS * COLS;

  if (DWELL < 2) begin : g_bad_dwell
    $error("DWELL must be at least 2");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("BLANK_CYCLES must be at least 1");
  end
  if (ROWS > (1 << ROW_W)) begin : g_bad_rows
    $error("ROWS exceeds row index width");
  end

  scan_state_t      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             running_q, running_d;
  logic [FW-1:0]    shadow_q, shadow_d;
  logic             shadow_full_q, shadow_full_d;
  logic [FW-1:0]    active_q, active_d;
  logic [ROWS-1:0]  row_sel_q, row_sel_d;
  logic [COLS-1:0]  col_q, col_d;

  logic advance, last_row, boundary, swap, accept, lit;
  logic dwell_en, dwell_tc, timer_clear, done_c;

  assign timer_clear = (state_q == IDLE);
  assign last_row    = (row_q == ROW_W'(ROWS - 1));
  // running_q means the previous cycle was lit/scanning; a cycle after enable
  // returns only re-lights the held position instead of advancing it.
  assign advance     = enable && running_q;

  scan_timer #(.LIMIT(DWELL)) u_dwell (
    .clk   (clock),
    .rst_n (reset),
    .clear (timer_clear),
    .en    (dwell_en),
    .tc    (dwell_tc)
  );

`ifdef SCAN_BLANK_EN
  logic blank_en, blank_tc;

  scan_timer #(.LIMIT(BLANK_CYCLES)) u_blank (
    .clk   (clock),
    .rst_n (reset),
    .clear (timer_clear),
    .en    (blank_en),
    .tc    (blank_tc)
  );
`endif

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    active_d      = active_q;
    boundary      = 1'b0;
    swap          = 1'b0;
    dwell_en      = 1'b0;
    done_c        = 1'b0;
`ifdef SCAN_BLANK_EN
    blank_en      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (enable && shadow_full_q) begin
          state_d = SCAN;
          row_d   = '0;
          swap    = 1'b1;
        end
      end
      SCAN: begin
`ifndef SCAN_BLANK_EN
        done_c = running_q && last_row && dwell_tc;
`endif
        if (advance) begin
          dwell_en = 1'b1;
          if (dwell_tc) begin
`ifdef SCAN_BLANK_EN
            state_d = BLANK;
`else
            row_d    = last_row ? '0 : row_q + ROW_W'(1);
            boundary = last_row;
`endif
          end
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        done_c = running_q && last_row && blank_tc;
        if (advance) begin
          blank_en = 1'b1;
          if (blank_tc) begin
            state_d  = SCAN;
            row_d    = last_row ? '0 : row_q + ROW_W'(1);
            boundary = last_row;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (boundary && shadow_full_q) begin
      swap = 1'b1;
    end

    accept = frame_valid && !shadow_full_q;
    if (swap) begin
      active_d      = shadow_q;
      shadow_d      = '0;
      shadow_full_d = 1'b0;
    end else if (accept) begin
      shadow_d      = frame;
      shadow_full_d = 1'b1;
    end

    running_d = enable && (state_d != IDLE);
    lit       = running_d && (state_d == SCAN);
    row_sel_d = lit ? (ROWS'(1) << row_d) : '0;
    col_d     = lit ? active_d[int'(row_d)*COLS +: COLS] : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      row_q         <= '0;
      running_q     <= 1'b0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      active_q      <= '0;
      row_sel_q     <= '0;
      col_q         <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      running_q     <= running_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      active_q      <= active_d;
      row_sel_q     <= row_sel_d;
      col_q         <= col_d;
    end
  end

  assign frame_ready = !shadow_full_q;
  assign row_sel     = row_sel_q;
  assign col_data    = col_q;
  assign row_idx     = row_q;
  assign frame_done  = done_c;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner (DWELL=4, 6x6); also valid with SCAN_BLANK_EN.
module tb_led_matrix_scanner;

  localparam int ROWS  = 6;
  localparam int COLS  = 6;
  localparam int DWELL = 4;
  localparam int BLNK  = 2;
`ifdef SCAN_BLANK_EN
  localparam bit BLANK_BUILD = 1'b1;
`else
  localparam bit BLANK_BUILD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [35:0] frame;
  logic        frame_valid;
  logic        frame_ready;
  logic [5:0]  row_sel;
  logic [5:0]  col_data;
  logic [2:0]  row_idx;
  logic        frame_done;

  always #5 clock = ~clock;

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK_CYCLES(BLNK)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .frame(frame),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .row_sel(row_sel),
    .col_data(col_data), .row_idx(row_idx), .frame_done(frame_done)
  );

  typedef struct packed {
    int unsigned n;
    logic [2:0]  idx;
    logic [5:0]  sel;
    logic [5:0]  col;
    logic        done;
    logic        rdy;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned nstep = 0;
  logic        exp_rdy;

  localparam logic [35:0] F1 = 36'h0_0000_003F;
  localparam logic [35:0] F2 = 36'hF_FFFF_FFFF;
  localparam logic [35:0] F3 = {6'h20, 6'h10, 6'h08, 6'h04, 6'h02, 6'h01};
  localparam logic [35:0] F4 = {6'h15, 6'h2A, 6'h15, 6'h2A, 6'h15, 6'h2A};

  // Monitor: one expected output vector per cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if ({row_idx, row_sel, col_data, frame_done, frame_ready} !==
            {e.idx, e.sel, e.col, e.done, e.rdy}) begin
          bad++;
          $display("FAIL step%0d: got idx=%0d sel=%b col=%b done=%b rdy=%b, want idx=%0d sel=%b col=%b done=%b rdy=%b",
                   e.n, row_idx, row_sel, col_data, frame_done, frame_ready,
                   e.idx, e.sel, e.col, e.done, e.rdy);
        end
      end
    end
  end

  task automatic push(input int r, input logic [5:0] sel, input logic [5:0] col,
                      input bit done);
    exp_t e;
    nstep++;
    e.n    = nstep;
    e.idx  = 3'(r);
    e.sel  = sel;
    e.col  = col;
    e.done = done;
    e.rdy  = exp_rdy;
    q.push_back(e);
  endtask

  // One clock: handshake bookkeeping for the producer, then queue expectation.
  task automatic step(input int r, input logic [5:0] sel, input logic [5:0] col,
                      input bit done, input bit swap);
    bit acc;
    @(posedge clock);
    acc = frame_valid && exp_rdy;
    #1;
    if (acc) begin
      exp_rdy     = 1'b0;
      frame_valid = 1'b0;
    end
    if (swap) exp_rdy = 1'b1;
    push(r, sel, col, done);
  endtask

  task automatic lit(input int r, input logic [35:0] f, input int n,
                     input bit done_last, input bit swap_first);
    for (int i = 0; i < n; i++)
      step(r, 6'(1 << r), f[r*6 +: 6], done_last && (i == n - 1), swap_first && (i == 0));
  endtask

  task automatic dark(input int r, input int n, input bit done_last);
    for (int i = 0; i < n; i++)
      step(r, 6'b0, 6'b0, done_last && (i == n - 1), 1'b0);
  endtask

  task automatic gap(input int r);
    if (BLANK_BUILD) dark(r, BLNK, r == ROWS - 1);
  endtask

  task automatic row(input int r, input logic [35:0] f, input bit swap_first);
    lit(r, f, DWELL, !BLANK_BUILD && (r == ROWS - 1), swap_first);
    gap(r);
  endtask

  task automatic frame_rows(input int from, input logic [35:0] f);
    for (int r = from; r < ROWS; r++) row(r, f, 1'b0);
  endtask

  initial begin
    reset       = 1'b0;
    enable      = 1'b1;
    frame_valid = 1'b0;
    frame       = '0;
    exp_rdy     = 1'b1;

    dark(0, 2, 1'b0);
    reset = 1'b1;
    dark(0, 2, 1'b0);

    // First frame: accept edge, then load edge lights row 0
    frame = F1; frame_valid = 1'b1;
    dark(0, 1, 1'b0);
    row(0, F1, 1'b1);
    row(1, F1, 1'b0);
    lit(2, F1, 2, 1'b0, 1'b0);
    frame = F2; frame_valid = 1'b1;
    lit(2, F1, 2, 1'b0, 1'b0);
    gap(2);
    frame_rows(3, F1);

    // F2 shown; offer F3 then F4 back-to-back within this frame
    lit(0, F2, 1, 1'b0, 1'b1);
    frame = F3; frame_valid = 1'b1;
    lit(0, F2, 1, 1'b0, 1'b0);
    frame = F4; frame_valid = 1'b1;
    lit(0, F2, DWELL - 2, 1'b0, 1'b0);
    gap(0);
    frame_rows(1, F2);

    // F3 swapped in; held F4 accepted on the following edge
    row(0, F3, 1'b1);
    frame_rows(1, F3);

    // F4: pause row 3 at dwell 2 for 10 cycles
    row(0, F4, 1'b1);
    row(1, F4, 1'b0);
    row(2, F4, 1'b0);
    lit(3, F4, 3, 1'b0, 1'b0);
    enable = 1'b0;
    dark(3, 10, 1'b0);
    enable = 1'b1;
    lit(3, F4, 2, 1'b0, 1'b0);
    gap(3);
    lit(4, F4, 2, 1'b0, 1'b0);

    // Asynchronous reset mid-row 4: outputs must clear before the next edge
    @(posedge clock);
    #1;
    reset   = 1'b0;
    exp_rdy = 1'b1;
    push(0, 6'b0, 6'b0, 1'b0);
    dark(0, 2, 1'b0);
    reset = 1'b1;
    dark(0, 6, 1'b0);

    @(negedge clock);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
